// File: rtl/seq_pkg.sv
// Shared types and helpers for the instruction sequencer.
// Holds the FSM state encoding, the instruction class bit index and the
// hold-length selection helper.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        HOLD      = 3'd2,
        FINISH    = 3'd3,
        STEP_WAIT = 3'd4
    } seq_state_e;

    // Bit 19 of a simple_cpu word: 0 = ALU, 1 = LOAD_R/STORE_R.
    localparam int unsigned CLASS_BIT = 19;

    // Width of the hold counter; comfortably covers any sane cycle count.
    localparam int unsigned CNT_W = 8;

    // Number of cycles a word must stay on the bus, selected by its class bit.
    function automatic logic [CNT_W-1:0] hold_cycles(
        input logic             class_bit,
        input logic [CNT_W-1:0] alu_n,
        input logic [CNT_W-1:0] mem_n
    );
        logic [CNT_W-1:0] n;
        if (class_bit) begin
            n = mem_n;
        end else begin
            n = alu_n;
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: one synchronous write port and an
// asynchronous read port. Contents are deliberately not reset so a loaded
// program survives a reset of the sequencer.
module seq_prog_mem #(
    parameter int unsigned WIDTH     = 20,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_BITS];

    // Write port: store the word on the rising edge when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: replays a stored program into simple_cpu, holding
// each word for the number of cycles its class needs (ALU vs LOAD_R/STORE_R).
// Optional build macro SEQ_SINGLE_STEP_EN adds a step input and a STEP_WAIT
// state that pauses between words until step is seen.
import seq_pkg::*;

module instr_sequencer #(
    parameter int unsigned INSTR_WIDTH    = 20,
    parameter int unsigned PROG_ADDR_BITS = 4,
    parameter int unsigned ALU_CYCLES     = 4,
    parameter int unsigned MEM_CYCLES     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_we,
    input  logic [PROG_ADDR_BITS-1:0] prog_addr,
    input  logic [INSTR_WIDTH-1:0]    prog_data,
    input  logic [PROG_ADDR_BITS:0]   prog_len,
    input  logic                      start,
    input  logic                      abort,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                      step,
`endif
    output logic [INSTR_WIDTH-1:0]    instruction,
    output logic                      issue,
    output logic [PROG_ADDR_BITS-1:0] pc,
    output logic                      busy,
    output logic                      done
);

    localparam logic [CNT_W-1:0]        ALU_N   = CNT_W'(ALU_CYCLES);
    localparam logic [CNT_W-1:0]        MEM_N   = CNT_W'(MEM_CYCLES);
    localparam logic [PROG_ADDR_BITS:0] DEPTH_L = {1'b1, {PROG_ADDR_BITS{1'b0}}};

    seq_state_e                  state_q, state_d;
    logic [PROG_ADDR_BITS-1:0]   pc_q, pc_d;
    logic [PROG_ADDR_BITS:0]     len_q, len_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0]      instr_q, instr_d;
    logic                        issue_q, issue_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic                        mem_we_s;
    logic [PROG_ADDR_BITS-1:0]   rd_addr_s;
    logic [INSTR_WIDTH-1:0]      rd_data_s;
    logic [INSTR_WIDTH-1:0]      word_s;
    logic [PROG_ADDR_BITS-1:0]   next_pc_s;
    logic [PROG_ADDR_BITS:0]     clamp_len_s;
    logic [CNT_W-1:0]            word_cnt_s;
    logic                        last_s;

    // Writes are only accepted while idle so a running program is never disturbed.
    assign mem_we_s  = prog_we && (state_q == IDLE);
    assign next_pc_s = pc_q + PROG_ADDR_BITS'(1);
    // Idle reads word 0 for an upcoming start; otherwise the word after pc.
    assign rd_addr_s = (state_q == IDLE) ? {PROG_ADDR_BITS{1'b0}} : next_pc_s;
    assign clamp_len_s = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_s    = ({1'b0, pc_q} == (len_q - (PROG_ADDR_BITS+1)'(1)));

    seq_prog_mem #(
        .WIDTH     (INSTR_WIDTH),
        .ADDR_BITS (PROG_ADDR_BITS)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we_s),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (rd_addr_s),
        .rdata_o (rd_data_s)
    );

    // Forward a same-cycle write to word 0 so a simultaneous start sees the new word.
    always_comb begin
        if (mem_we_s && (prog_addr == {PROG_ADDR_BITS{1'b0}})) begin
            word_s = prog_data;
        end else begin
            word_s = rd_data_s;
        end
        // The ISSUE cycle is the first hold cycle, so HOLD runs for N-1 more.
        word_cnt_s = hold_cycles(word_s[CLASS_BIT], ALU_N, MEM_N) - CNT_W'(1);
    end

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        issue_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d  = {PROG_ADDR_BITS{1'b0}};
                    len_d = clamp_len_s;
                    if (clamp_len_s == {(PROG_ADDR_BITS+1){1'b0}}) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ISSUE;
                        instr_d = word_s;
                        cnt_d   = word_cnt_s;
                        issue_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    if (last_s) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
`ifdef SEQ_SINGLE_STEP_EN
                        state_d = STEP_WAIT;
`else
                        state_d = ISSUE;
                        pc_d    = next_pc_s;
                        instr_d = word_s;
                        cnt_d   = word_cnt_s;
                        issue_d = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            STEP_WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (step) begin
                    state_d = ISSUE;
                    pc_d    = next_pc_s;
                    instr_d = word_s;
                    cnt_d   = word_cnt_s;
                    issue_d = 1'b1;
                end else begin
                    state_d = STEP_WAIT;
                end
            end
`endif
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; memory contents are not touched by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= {PROG_ADDR_BITS{1'b0}};
            len_q   <= {(PROG_ADDR_BITS+1){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            instr_q <= {INSTR_WIDTH{1'b0}};
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            issue_q <= issue_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction = instr_q;
    assign issue       = issue_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer. Inputs are driven and
// outputs sampled on the falling edge; the design acts on the rising edge.
// The step scenario is included when SEQ_SINGLE_STEP_EN is defined.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        abort;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif
    logic [19:0] instruction;
    logic        issue;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .abort       (abort),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .instruction (instruction),
        .issue       (issue),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    task automatic write_word(input logic [3:0] a, input logic [19:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Raise start for one cycle; returns in cycle 1 of the run.
    task automatic start_run(input logic [4:0] len);
        prog_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 20'd0;
        prog_len = 5'd0; start = 1'b0; abort = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        @(negedge clk); @(negedge clk);
        n_tests++; if (instruction !== 20'd0) begin n_fail++; $display("FAIL reset_instr got %h exp %h", instruction, 20'd0); end
        n_tests++; if (issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue got %b exp 0", issue); end
        n_tests++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc got %0d exp 0", pc); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_program_run;
        logic [19:0] ei;
        logic [3:0]  ep;
        write_word(4'd0, 20'h47000);
        write_word(4'd1, 20'h53000);
        write_word(4'd2, 20'hD80F0);
        start_run(5'd3);
        for (int c = 1; c <= 13; c++) begin
            ei = (c <= 4) ? 20'h47000 : (c <= 8) ? 20'h53000 : 20'hD80F0;
            ep = (c <= 4) ? 4'd0 : (c <= 8) ? 4'd1 : 4'd2;
            n_tests++; if (instruction !== ei) begin n_fail++; $display("FAIL run_instr c=%0d got %h exp %h", c, instruction, ei); end
            n_tests++; if (issue !== ((c == 1) || (c == 5) || (c == 9))) begin n_fail++; $display("FAIL run_issue c=%0d got %b", c, issue); end
            n_tests++; if (busy !== (c <= 11)) begin n_fail++; $display("FAIL run_busy c=%0d got %b", c, busy); end
            n_tests++; if (done !== (c == 12)) begin n_fail++; $display("FAIL run_done c=%0d got %b", c, done); end
            n_tests++; if (pc !== ep) begin n_fail++; $display("FAIL run_pc c=%0d got %0d exp %0d", c, pc, ep); end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_len;
        start_run(5'd0);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b exp 1", done); end
        n_tests++; if (issue !== 1'b0) begin n_fail++; $display("FAIL zero_issue got %b exp 0", issue); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b exp 0", busy); end
        n_tests++; if (instruction !== 20'hD80F0) begin n_fail++; $display("FAIL zero_instr got %h exp %h", instruction, 20'hD80F0); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done2 got %b exp 0", done); end
    endtask

    task automatic test_len_clamp;
        logic [19:0] exp_w [16];
        int n_issue = 0;
        int done_c  = 0;
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = 20'(i);
            if ((i % 2) == 1) exp_w[i][19] = 1'b1;
            write_word(4'(i), exp_w[i]);
        end
        start_run(5'd20);
        for (int c = 1; c <= 120; c++) begin
            if (issue === 1'b1) begin
                n_tests++; if (pc !== 4'(n_issue)) begin n_fail++; $display("FAIL clamp_pc n=%0d got %0d", n_issue, pc); end
                n_tests++; if (instruction !== exp_w[n_issue % 16]) begin n_fail++; $display("FAIL clamp_instr n=%0d got %h exp %h", n_issue, instruction, exp_w[n_issue % 16]); end
                n_issue++;
            end
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
            @(negedge clk);
        end
        n_tests++; if (n_issue != 16) begin n_fail++; $display("FAIL clamp_issues got %0d exp 16", n_issue); end
        n_tests++; if (done_c != 57) begin n_fail++; $display("FAIL clamp_done_cycle got %0d exp 57", done_c); end
        @(negedge clk);
    endtask

    task automatic test_write_start;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 20'h12345;
        prog_len = 5'd1; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        n_tests++; if (instruction !== 20'h12345) begin n_fail++; $display("FAIL ws_instr got %h exp %h", instruction, 20'h12345); end
        n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL ws_issue got %b exp 1", issue); end
        repeat (4) @(negedge clk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ws_done got %b exp 1", done); end
        @(negedge clk);
    endtask

    task automatic test_abort_ignore;
        write_word(4'd0, 20'h47000);
        write_word(4'd1, 20'h53000);
        start_run(5'd2);
        @(negedge clk);
        // cycle 2: stray start and write while busy
        prog_len = 5'd1; start = 1'b1;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 20'hFFFFF;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        n_tests++; if ((pc !== 4'd0) || (busy !== 1'b1) || (instruction !== 20'h47000)) begin n_fail++; $display("FAIL busy_start got pc=%0d busy=%b instr=%h exp pc=0 busy=1 instr=47000", pc, busy, instruction); end
        repeat (4) @(negedge clk);
        // cycle 7: second HOLD cycle of word 2
        n_tests++; if ((pc !== 4'd1) || (instruction !== 20'h53000)) begin n_fail++; $display("FAIL pre_abort got pc=%0d instr=%h exp pc=1 instr=53000", pc, instruction); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
        n_tests++; if (instruction !== 20'h53000) begin n_fail++; $display("FAIL abort_instr got %h exp %h", instruction, 20'h53000); end
        n_tests++; if (pc !== 4'd1) begin n_fail++; $display("FAIL abort_pc got %0d exp 1", pc); end
        for (int c = 0; c < 6; c++) begin
            n_tests++; if ((done !== 1'b0) || (issue !== 1'b0)) begin n_fail++; $display("FAIL abort_quiet c=%0d got done=%b issue=%b exp 0 0", c, done, issue); end
            @(negedge clk);
        end
        start_run(5'd1);
        n_tests++; if (instruction !== 20'h47000) begin n_fail++; $display("FAIL mem_kept got %h exp %h", instruction, 20'h47000); end
        repeat (4) @(negedge clk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL readback_done got %b exp 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        start_run(5'd2);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (instruction !== 20'd0) begin n_fail++; $display("FAIL mid_rst_instr got %h exp 0", instruction); end
        n_tests++; if ((busy !== 1'b0) || (issue !== 1'b0) || (done !== 1'b0) || (pc !== 4'd0)) begin n_fail++; $display("FAIL mid_rst_outs got busy=%b issue=%b done=%b pc=%0d exp 0 0 0 0", busy, issue, done, pc); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_run(5'd2);
        n_tests++; if ((instruction !== 20'h47000) || (pc !== 4'd0) || (issue !== 1'b1)) begin n_fail++; $display("FAIL replay_w1 got instr=%h pc=%0d issue=%b exp 47000 0 1", instruction, pc, issue); end
        repeat (4) @(negedge clk);
        n_tests++; if ((instruction !== 20'h53000) || (pc !== 4'd1) || (issue !== 1'b1)) begin n_fail++; $display("FAIL replay_w2 got instr=%h pc=%0d issue=%b exp 53000 1 1", instruction, pc, issue); end
        repeat (4) @(negedge clk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL replay_done got %b exp 1", done); end
        @(negedge clk);
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_step;
        write_word(4'd0, 20'h47000);
        write_word(4'd1, 20'hD80F0);
        start_run(5'd2);
        repeat (4) @(negedge clk);
        for (int c = 5; c <= 7; c++) begin
            n_tests++; if ((busy !== 1'b1) || (issue !== 1'b0) || (instruction !== 20'h47000) || (pc !== 4'd0)) begin n_fail++; $display("FAIL step_wait c=%0d got busy=%b issue=%b instr=%h pc=%0d", c, busy, issue, instruction, pc); end
            if (c < 7) @(negedge clk);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        n_tests++; if ((issue !== 1'b1) || (pc !== 4'd1) || (instruction !== 20'hD80F0)) begin n_fail++; $display("FAIL step_issue got issue=%b pc=%0d instr=%h exp 1 1 d80f0", issue, pc, instruction); end
        @(negedge clk);
        n_tests++; if (issue !== 1'b0) begin n_fail++; $display("FAIL step_single got issue=%b exp 0", issue); end
        repeat (2) @(negedge clk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL step_done got %b exp 1", done); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_program_run();
        test_zero_len();
        test_len_clamp();
        test_write_start();
        test_abort_ignore();
        test_reset_mid_run();
`ifdef SEQ_SINGLE_STEP_EN
        test_step();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Producer side of the simple_cpu instruction interface: stores a short program and drives `instruction` into simple_cpu.
- Holds each word for the number of clock edges the CPU needs: 4 for ALU, 3 for LOAD_R/STORE_R.
- Replaces hand-timed instruction stimulus. Sits beside simple_cpu in the top level, sharing its clock.

Parameters:
- INSTR_WIDTH, 20, instruction word width; must match simple_cpu.
- PROG_ADDR_BITS, 4, program memory address bits (16 entries).
- ALU_CYCLES, 4, hold cycles for an ALU instruction (bit 19 = 0).
- MEM_CYCLES, 3, hold cycles for a LOAD_R/STORE_R instruction (bit 19 = 1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- prog_we  in  1  program memory write strobe; honoured only in IDLE.
- prog_addr  in  PROG_ADDR_BITS  program memory write address.
- prog_data  in  INSTR_WIDTH  program memory write data.
- prog_len  in  PROG_ADDR_BITS+1  number of instructions to run; sampled on start.
- start  in  1  run request; honoured only in IDLE.
- abort  in  1  synchronous stop request.
- instruction  out  INSTR_WIDTH  word driven to simple_cpu.
- issue  out  1  one-cycle pulse in the first cycle each new word is driven.
- pc  out  PROG_ADDR_BITS  index of the word currently driven.
- busy  out  1  high in ISSUE and HOLD.
- done  out  1  one-cycle pulse when a run completes normally.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - instruction=0, issue=0, pc=0, busy=0, done=0, hold counter=0, latched length=0.
  - Program memory is not reset: contents survive reset and are undefined at power-up.
- States: IDLE, ISSUE, HOLD, FINISH.
- IDLE:
  - prog_we writes mem[prog_addr]=prog_data on the edge.
  - start=1 latches len=min(prog_len, 2^PROG_ADDR_BITS) and pc=0.
  - If len=0, go to FINISH. Otherwise go to ISSUE.
  - prog_we and start arriving together: the write lands first, so a start in the same cycle sees the new word.
- ISSUE (1 cycle):
  - instruction<=mem[pc] (registered, visible in this cycle); issue=1.
  - Hold count = ALU_CYCLES if mem[pc][19]==0, else MEM_CYCLES.
  - Go to HOLD.
- HOLD:
  - The word stays stable. The ISSUE cycle counts as hold cycle 1, so the total visible time is exactly N cycles (N = hold count).
  - After the last hold cycle: if pc==len-1, go to FINISH. Otherwise pc<=pc+1 and go to ISSUE.
  - Consecutive words are back-to-back with no gap cycle.
- FINISH (1 cycle): done=1, busy=0, then go to IDLE.
- instruction keeps its last issued value in IDLE/FINISH. It is never driven to 0 between runs, because 0 is a valid ADD to simple_cpu.
- start while busy is ignored. prog_we while busy is ignored (no write).
- abort=1 in ISSUE/HOLD: go to IDLE next edge with no done pulse; instruction holds its value; pc holds. abort in IDLE/FINISH has no effect, and FINISH still pulses done.
- pc never wraps within a run, because len ≤ depth.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined:
  - Extra input step (1 bit) and extra state STEP_WAIT.
  - After HOLD completes for a non-final word, enter STEP_WAIT. busy stays 1 and the word is held.
  - Advance to ISSUE (pc+1) on the first cycle step=1. Consecutive steps do not skip words.
  - abort is honoured in STEP_WAIT.
- When undefined: no step port and no STEP_WAIT; behaviour is exactly as above.

Decomposition:
- Package seq_pkg holds:
  - State enum {IDLE, ISSUE, HOLD, FINISH, STEP_WAIT}.
  - Localparam for the class-bit index (19).
  - Function hold_cycles(word) returning ALU_CYCLES or MEM_CYCLES.
- One sub-module, seq_prog_mem: single write port, asynchronous-read register array of depth 2^PROG_ADDR_BITS. The FSM, counter and pc stay in the top.

Test Plan:
- Reset mid-run: assert rst=0 during HOLD of word 1 → all outputs go to reset values immediately (no clock needed); after release, a new start replays from pc=0 using the retained memory.
- Program load, then start, prog_len=3:
  - Words: 0x47000 (ALU), 0x53000 (ALU), 0xD80F0 (STORE_R).
  - Required: 0x47000 for 4 cycles, 0x53000 for 4 cycles, 0xD80F0 for 3 cycles.
  - issue pulses at cycles 1, 5 and 9 after start; done pulses 1 cycle after the last hold.
  - With simple_cpu attached: reg1=7 and DATA_MEM[17]=7.
- prog_len=0 start → done pulses in the cycle after start, no issue pulse, instruction unchanged.
- prog_len=20 with PROG_ADDR_BITS=4 → exactly 16 issue pulses, then done; pc never exceeds 15.
- Abort in the 2nd HOLD cycle of word 2 → IDLE next edge, no done, instruction held; start during that run and prog_we while busy are both ignored (memory read back unchanged).
- SEQ_SINGLE_STEP_EN, 2 words → word 1 held until step; one step pulse gives exactly one issue; done follows word 2's hold.
